add_share_arbiter: RTL and testbench

- Shares one instance of the team's 22-bit Brent-Kung prefix adder (PPA_Brent_Kung_22bit) between NREQ requesters, using round-robin arbitration.
- Supports add, subtract and multi-beat carry-chained operations for wide operands.
- Each request is a valid/ready beat. Results return on a single registered response channel, tagged with the requester ID.
- Sits between the arithmetic clients and the shared adder datapath.

---
 rtl/add_share_pkg.sv | 16 +
 rtl/PPA_Brent_Kung_22bit.sv | 40 ++++
 rtl/rr_pick.sv | 29 ++
 rtl/add_share_arbiter.sv | 177 +++++++++++++++++
 tb/tb_add_share_arbiter.sv | 200 ++++++++++++++++++++
 5 files changed

// File: rtl/add_share_pkg.sv
// Shared types and helpers for the adder-sharing arbiter.
package add_share_pkg;

  localparam int unsigned ADD_W = 22;

  typedef enum logic {
    ST_OPEN = 1'b0,
    ST_LOCK = 1'b1
  } state_t;

  // Requester ID width; a single requester still gets a 1-bit ID.
  function automatic int unsigned id_width(input int unsigned n);
    return (n < 2) ? 1 : 32'($clog2(n));
  endfunction

endpackage

// File: rtl/PPA_Brent_Kung_22bit.sv
// 22-bit Brent-Kung parallel-prefix adder with carry-in and carry-out.
module PPA_Brent_Kung_22bit (
  input  logic [21:0] a,
  input  logic [21:0] b,
  input  logic        cin,
  output logic [21:0] sum,
  output logic        cout
);

  localparam int unsigned N  = 22;
  localparam int unsigned NP = 32;

  logic [NP-1:0] w_g;
  logic [NP-1:0] w_p;
  logic [N-1:0]  w_h;

  // Prefix tree padded to a power of two so the down-sweep reaches every bit.
  always_comb begin
    w_g    = NP'(a & b);
    w_p    = NP'(a ^ b);
    w_g[0] = w_g[0] | (w_p[0] & cin);
    for (int k = 0; k < 5; k++) begin
      for (int i = (2 << k) - 1; i < NP; i += (2 << k)) begin
        w_g[i] = w_g[i] | (w_p[i] & w_g[i - (1 << k)]);
        w_p[i] = w_p[i] & w_p[i - (1 << k)];
      end
    end
    for (int k = 3; k >= 0; k--) begin
      for (int i = 3 * (1 << k) - 1; i < NP; i += (2 << k)) begin
        w_g[i] = w_g[i] | (w_p[i] & w_g[i - (1 << k)]);
        w_p[i] = w_p[i] & w_p[i - (1 << k)];
      end
    end
  end

  assign w_h  = a ^ b;
  assign sum  = w_h ^ {w_g[N-2:0], cin};
  assign cout = w_g[N-1];

endmodule

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set request at or after ptr, cyclically.
module rr_pick #(
  parameter int unsigned NREQ = 4,
  parameter int unsigned IDW  = 2
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  ptr,
  output logic [NREQ-1:0] grant,
  output logic [IDW-1:0]  idx,
  output logic            any
);

  always_comb begin
    logic [IDW-1:0] v_j;
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    v_j   = '0;
    for (int k = 0; k < NREQ; k++) begin
      v_j = IDW'((32'(ptr) + 32'(k)) % NREQ);
      if (!any && req[v_j]) begin
        any        = 1'b1;
        idx        = v_j;
        grant[v_j] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/add_share_arbiter.sv
// Round-robin sharing of one 22-bit prefix adder among NREQ requesters,
// with carry-chained multi-beat locking and a single registered response.
module add_share_arbiter
  import add_share_pkg::*;
#(
  parameter int unsigned WIDTH = ADD_W,
  parameter int unsigned NREQ  = 4,
  parameter int unsigned IDW   = id_width(NREQ)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NREQ-1:0]       req_valid,
  output logic [NREQ-1:0]       req_ready,
  input  logic [NREQ*WIDTH-1:0] req_a,
  input  logic [NREQ*WIDTH-1:0] req_b,
  input  logic [NREQ-1:0]       req_cin,
  input  logic [NREQ-1:0]       req_sub,
  input  logic [NREQ-1:0]       req_chain,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [WIDTH-1:0]      rsp_sum,
  output logic                  rsp_cout,
  output logic                  rsp_ovf,
  output logic [IDW-1:0]        rsp_id,
  output logic                  rsp_last
);

  state_t           r_state;
  logic [IDW-1:0]   r_rr_ptr;
  logic [IDW-1:0]   r_lock_id;
  logic             r_carry_q;

  logic             r_rsp_valid;
  logic [WIDTH-1:0] r_rsp_sum;
  logic             r_rsp_cout;
  logic             r_rsp_ovf;
  logic [IDW-1:0]   r_rsp_id;
  logic             r_rsp_last;

  logic             w_out_free;
  logic [NREQ-1:0]  w_pick_grant;
  logic [IDW-1:0]   w_pick_idx;
  logic             w_pick_any;
  logic [NREQ-1:0]  w_lock_oh;
  logic [NREQ-1:0]  w_grant;
  logic [IDW-1:0]   w_gidx;
  logic             w_fire;
  logic [IDW-1:0]   w_ptr_nxt;

  logic [WIDTH-1:0] w_a;
  logic [WIDTH-1:0] w_b;
  logic             w_cin;
  logic             w_sub;
  logic             w_chain;
  logic [WIDTH-1:0] w_b_eff;
  logic             w_cin_eff;
  logic [WIDTH-1:0] w_sum;
  logic             w_cout;
  logic             w_ovf;

  rr_pick #(
    .NREQ (NREQ),
    .IDW  (IDW)
  ) u_rr_pick (
    .req   (req_valid),
    .ptr   (r_rr_ptr),
    .grant (w_pick_grant),
    .idx   (w_pick_idx),
    .any   (w_pick_any)
  );

  always_comb begin
    w_lock_oh = '0;
    for (int i = 0; i < NREQ; i++) begin
      w_lock_oh[i] = (r_lock_id == IDW'(i));
    end
  end

  // A locked requester owns the adder whether or not it is currently valid.
  assign w_out_free = !r_rsp_valid || rsp_ready;
  assign w_grant    = (r_state == ST_LOCK) ? w_lock_oh : w_pick_grant;
  assign w_gidx     = (r_state == ST_LOCK) ? r_lock_id : w_pick_idx;
  assign req_ready  = w_grant & {NREQ{w_out_free}};
  assign w_fire     = w_out_free &&
                      ((r_state == ST_LOCK) ? |(req_valid & w_lock_oh) : w_pick_any);
  assign w_ptr_nxt  = (w_gidx == IDW'(NREQ - 1)) ? '0 : w_gidx + IDW'(1);

  // Operand mux from the granted requester's slice.
  always_comb begin
    w_a     = '0;
    w_b     = '0;
    w_cin   = 1'b0;
    w_sub   = 1'b0;
    w_chain = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      if (w_grant[i]) begin
        w_a     = req_a[i*WIDTH +: WIDTH];
        w_b     = req_b[i*WIDTH +: WIDTH];
        w_cin   = req_cin[i];
        w_sub   = req_sub[i];
        w_chain = req_chain[i];
      end
    end
  end

  assign w_b_eff   = w_sub ? ~w_b : w_b;
  assign w_cin_eff = (r_state == ST_LOCK) ? r_carry_q : (w_sub | w_cin);
  assign w_ovf     = (w_a[WIDTH-1] == w_b_eff[WIDTH-1]) && (w_sum[WIDTH-1] != w_a[WIDTH-1]);

  PPA_Brent_Kung_22bit u_adder (
    .a    (w_a),
    .b    (w_b_eff),
    .cin  (w_cin_eff),
    .sum  (w_sum),
    .cout (w_cout)
  );

  // Lock FSM and response register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_OPEN;
      r_rr_ptr    <= '0;
      r_lock_id   <= '0;
      r_carry_q   <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_rsp_sum   <= '0;
      r_rsp_cout  <= 1'b0;
      r_rsp_ovf   <= 1'b0;
      r_rsp_id    <= '0;
      r_rsp_last  <= 1'b0;
    end else begin
      if (w_fire) begin
        r_rsp_valid <= 1'b1;
        r_rsp_sum   <= w_sum;
        r_rsp_cout  <= w_cout;
        r_rsp_ovf   <= w_ovf;
        r_rsp_id    <= w_gidx;
        r_rsp_last  <= !w_chain;
      end else if (rsp_ready) begin
        r_rsp_valid <= 1'b0;
      end

      if (w_fire) begin
        case (r_state)
          ST_OPEN: begin
            if (w_chain) begin
              r_state   <= ST_LOCK;
              r_lock_id <= w_gidx;
              r_carry_q <= w_cout;
            end else begin
              r_rr_ptr  <= w_ptr_nxt;
              r_carry_q <= 1'b0;
            end
          end
          ST_LOCK: begin
            if (w_chain) begin
              r_carry_q <= w_cout;
            end else begin
              r_state   <= ST_OPEN;
              r_rr_ptr  <= w_ptr_nxt;
              r_carry_q <= 1'b0;
            end
          end
          default: r_state <= ST_OPEN;
        endcase
      end
    end
  end

  assign rsp_valid = r_rsp_valid;
  assign rsp_sum   = r_rsp_sum;
  assign rsp_cout  = r_rsp_cout;
  assign rsp_ovf   = r_rsp_ovf;
  assign rsp_id    = r_rsp_id;
  assign rsp_last  = r_rsp_last;

endmodule

// File: tb/tb_add_share_arbiter.sv
// Directed self-checking bench for add_share_arbiter (NREQ=4, WIDTH=22).
module tb_add_share_arbiter;

  localparam int unsigned W = 22;
  localparam int unsigned N = 4;

  logic           clk;
  logic           rst_n;
  logic [N-1:0]   req_valid;
  logic [N-1:0]   req_ready;
  logic [N*W-1:0] req_a;
  logic [N*W-1:0] req_b;
  logic [N-1:0]   req_cin;
  logic [N-1:0]   req_sub;
  logic [N-1:0]   req_chain;
  logic           rsp_valid;
  logic           rsp_ready;
  logic [W-1:0]   rsp_sum;
  logic           rsp_cout;
  logic           rsp_ovf;
  logic [1:0]     rsp_id;
  logic           rsp_last;

  int n_assert;
  int n_fail;

  add_share_arbiter #(.NREQ(N)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_cin   (req_cin),
    .req_sub   (req_sub),
    .req_chain (req_chain),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_sum   (rsp_sum),
    .rsp_cout  (rsp_cout),
    .rsp_ovf   (rsp_ovf),
    .rsp_id    (rsp_id),
    .rsp_last  (rsp_last)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_rsp(input string tag, input logic [W-1:0] sum, input logic cout,
                           input logic ovf, input logic [1:0] id, input logic last);
    check({tag, "_valid"}, 32'(rsp_valid), 32'd1);
    check({tag, "_sum"},   32'(rsp_sum),   32'(sum));
    check({tag, "_cout"},  32'(rsp_cout),  32'(cout));
    check({tag, "_ovf"},   32'(rsp_ovf),   32'(ovf));
    check({tag, "_id"},    32'(rsp_id),    32'(id));
    check({tag, "_last"},  32'(rsp_last),  32'(last));
  endtask

  task automatic set_req(input int i, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic cin, input logic sub, input logic chain);
    req_valid[i]     = 1'b1;
    req_a[i*W +: W]  = a;
    req_b[i*W +: W]  = b;
    req_cin[i]       = cin;
    req_sub[i]       = sub;
    req_chain[i]     = chain;
  endtask

  task automatic clr_reqs();
    req_valid = '0;
    req_a     = '0;
    req_b     = '0;
    req_cin   = '0;
    req_sub   = '0;
    req_chain = '0;
  endtask

  initial begin
    n_assert  = 0;
    n_fail    = 0;
    rst_n     = 1'b0;
    rsp_ready = 1'b1;
    clr_reqs();

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_valid", 32'(rsp_valid), 32'd0);
    check("rst_sum",   32'(rsp_sum),   32'd0);
    check("rst_cout",  32'(rsp_cout),  32'd0);
    check("rst_ovf",   32'(rsp_ovf),   32'd0);
    check("rst_id",    32'(rsp_id),    32'd0);
    check("rst_last",  32'(rsp_last),  32'd0);
    check("rst_ready", 32'(req_ready), 32'd0);
    rst_n = 1'b1;

    // Single add with wrap to zero
    @(negedge clk);
    set_req(0, 22'h3FFFFF, 22'h000001, 1'b0, 1'b0, 1'b0);
    #1 check("add_ready", 32'(req_ready), 32'b0001);
    @(negedge clk);
    clr_reqs();
    check_rsp("add", 22'h000000, 1'b1, 1'b0, 2'd0, 1'b1);
    @(negedge clk);
    check("add_drain", 32'(rsp_valid), 32'd0);

    // Subtract 5 - 7
    set_req(2, 22'd5, 22'd7, 1'b0, 1'b1, 1'b0);
    @(negedge clk);
    clr_reqs();
    check_rsp("sub", 22'h3FFFFE, 1'b0, 1'b0, 2'd2, 1'b1);

    // Negative + negative overflow; pointer then wraps to 0
    set_req(3, 22'h200000, 22'h200000, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    clr_reqs();
    check_rsp("ovf", 22'h000000, 1'b1, 1'b1, 2'd3, 1'b1);

    // Round-robin with all four requesting
    for (int i = 0; i < 4; i++) set_req(i, 22'(16 * i + 1), 22'(i), 1'b0, 1'b0, 1'b0);
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      check($sformatf("rr%0d_valid", k), 32'(rsp_valid), 32'd1);
      check($sformatf("rr%0d_id", k),    32'(rsp_id),    32'(k % 4));
      check($sformatf("rr%0d_sum", k),   32'(rsp_sum),   32'(17 * (k % 4) + 1));
    end
    clr_reqs();

    // Carry-chained op on req1 while req3 contends
    set_req(1, 22'h3FFFFF, 22'h000001, 1'b0, 1'b0, 1'b1);
    set_req(3, 22'h000010, 22'h000020, 1'b0, 1'b0, 1'b0);
    #1 check("ch1_ready", 32'(req_ready), 32'b0010);
    @(negedge clk);
    check_rsp("ch1", 22'h000000, 1'b1, 1'b0, 2'd1, 1'b0);
    set_req(1, 22'h000000, 22'h000000, 1'b1, 1'b0, 1'b0);
    #1 check("ch2_ready", 32'(req_ready), 32'b0010);
    @(negedge clk);
    check_rsp("ch2", 22'h000001, 1'b0, 1'b0, 2'd1, 1'b1);
    req_valid[1] = 1'b0;
    #1 check("ch3_ready", 32'(req_ready), 32'b1000);
    @(negedge clk);
    check_rsp("ch3", 22'h000030, 1'b0, 1'b0, 2'd3, 1'b1);
    clr_reqs();
    @(negedge clk);
    check("ch_drain", 32'(rsp_valid), 32'd0);

    // Backpressure: held response stalls grants, release fires same cycle
    rsp_ready = 1'b0;
    set_req(0, 22'h012345, 22'h011111, 1'b0, 1'b0, 1'b0);
    #1 check("bp_ready0", 32'(req_ready), 32'b0001);
    @(negedge clk);
    clr_reqs();
    set_req(2, 22'd1, 22'd2, 1'b0, 1'b0, 1'b0);
    #1 check_rsp("bp0", 22'h023456, 1'b0, 1'b0, 2'd0, 1'b1);
    check("bp_stall0", 32'(req_ready), 32'b0000);
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      check_rsp($sformatf("bp%0d", k), 22'h023456, 1'b0, 1'b0, 2'd0, 1'b1);
      check($sformatf("bp_stall%0d", k), 32'(req_ready), 32'b0000);
    end
    rsp_ready = 1'b1;
    #1 check("bp_release", 32'(req_ready), 32'b0100);
    @(negedge clk);
    check_rsp("bp_next", 22'h000003, 1'b0, 1'b0, 2'd2, 1'b1);
    clr_reqs();

    // Reset in the middle of a chain
    set_req(0, 22'h3FFFFF, 22'h000001, 1'b0, 1'b0, 1'b1);
    #1 check("rc_ready", 32'(req_ready), 32'b0001);
    @(negedge clk);
    check_rsp("rc_beat", 22'h000000, 1'b1, 1'b0, 2'd0, 1'b0);
    clr_reqs();
    rst_n = 1'b0;
    #1 check("rc_rst_valid", 32'(rsp_valid), 32'd0);
    check("rc_rst_ready", 32'(req_ready), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    set_req(2, 22'd9, 22'd9, 1'b0, 1'b0, 1'b0);
    set_req(3, 22'd5, 22'd6, 1'b0, 1'b0, 1'b0);
    #1 check("rc_ptr0", 32'(req_ready), 32'b0100);
    req_valid[2] = 1'b0;
    #1 check("rc_open", 32'(req_ready), 32'b1000);
    @(negedge clk);
    check_rsp("rc_after", 22'h00000B, 1'b0, 1'b0, 2'd3, 1'b1);
    clr_reqs();
    @(negedge clk);
    check("rc_drain", 32'(rsp_valid), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
